// File: rtl/ntt_mod_addsub_pipe.sv
// Two-stage pipelined modular adder/subtractor with valid/ready on both sides: S=(A+B) mod Q, D=(A-B) mod Q.
// Optional sticky input range flag built when NTT_MODADD_RANGE_CHECK_EN is defined.
module ntt_mod_addsub_pipe #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] S_o,
  output logic [WIDTH-1:0] D_o,
  output logic             err_o
);

  if (Q <= 1 || Q >= (1 << WIDTH)) begin : g_bad_q
    $error("ntt_mod_addsub_pipe: Q must satisfy 1 < Q < 2**WIDTH");
  end

  localparam logic [WIDTH:0]   Q_EXT = (WIDTH+1)'(Q);
  localparam logic [WIDTH-1:0] Q_W   = WIDTH'(Q);

  logic             r_v1;
  logic             r_v2;
  logic [WIDTH:0]   r_s1;
  logic [WIDTH:0]   r_d1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_d2;

  logic             w_adv1;
  logic             w_adv2;
  logic [WIDTH:0]   w_s_sub;
  logic [WIDTH-1:0] w_s_corr;
  logic [WIDTH-1:0] w_d_corr;

  // A stage may load when it is empty or when the stage after it is draining.
  assign w_adv2  = ~r_v2 | ready_i;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign ready_o = w_adv1;
  assign valid_o = r_v2;
  assign S_o     = r_s2;
  assign D_o     = r_d2;

  assign w_s_sub  = r_s1 - Q_EXT;
  assign w_s_corr = (r_s1 >= Q_EXT) ? w_s_sub[WIDTH-1:0] : r_s1[WIDTH-1:0];
  assign w_d_corr = r_d1[WIDTH] ? (r_d1[WIDTH-1:0] + Q_W) : r_d1[WIDTH-1:0];

  // NOTE: all pipeline state uses non-blocking assignments so both stages
  // shift on the same edge using the values from before that edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
      r_d1 <= '0;
    end else if (w_adv1) begin
      r_v1 <= valid_i;
      r_s1 <= {1'b0, A_i} + {1'b0, B_i};
      r_d1 <= {1'b0, A_i} - {1'b0, B_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
      r_d2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      r_s2 <= w_s_corr;
      r_d2 <= w_d_corr;
    end
  end

`ifdef NTT_MODADD_RANGE_CHECK_EN
  logic r_err;
  logic w_out_of_range;

  assign w_out_of_range = (A_i >= Q_W) | (B_i >= Q_W);
  assign err_o          = r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (valid_i && w_adv1 && w_out_of_range) begin
      r_err <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_mod_addsub_pipe.sv
// Self-checking bench for ntt_mod_addsub_pipe: scoreboard queue plus occupancy model,
// directed scenarios and randomized valid/ready traffic.
module tb_ntt_mod_addsub_pipe;
  localparam int WIDTH = 12;
  localparam int Q     = 3329;
  localparam int MASK  = (1 << WIDTH) - 1;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] A_i = '0;
  logic [WIDTH-1:0] B_i = '0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [WIDTH-1:0] S_o;
  logic [WIDTH-1:0] D_o;
  logic             err_o;

  int   n_vec = 0;
  int   n_mis = 0;
  int   occ = 0;
  int   acc_count = 0;
  int   out_count = 0;
  logic err_exp = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ntt_mod_addsub_pipe #(.WIDTH(WIDTH), .Q(Q)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(A_i), .B_i(B_i), .valid_o(valid_o), .ready_i(ready_i),
    .S_o(S_o), .D_o(D_o), .err_o(err_o)
  );

  // Reference: plain integer arithmetic, one correction, result truncated to WIDTH bits.
  function automatic exp_t ref_model(input int a, input int b);
    exp_t e;
    int s, d;
    s = a + b;
    if (s >= Q) s = s - Q;
    d = a - b;
    if (d < 0) d = d + Q;
    e.s = WIDTH'(s & MASK);
    e.d = WIDTH'(d & MASK);
    return e;
  endfunction

  // One clock cycle: drive at negedge, compare #1 later, update model.
  task automatic step(input logic vi, input int a, input int b, input logic ri);
    exp_t e;
    logic acc, drn;
    @(negedge clk);
    valid_i = vi; A_i = WIDTH'(a); B_i = WIDTH'(b); ready_i = ri;
    #1;
    n_vec++;
    if (ready_o !== ((occ < 2) || ri)) begin
      n_mis++;
      $display("FAIL ready_o: got %b expected %b (occupancy %0d)", ready_o, (occ < 2) || ri, occ);
    end
    n_vec++;
    if (err_o !== err_exp) begin
      n_mis++;
      $display("FAIL err_o: got %b expected %b", err_o, err_exp);
    end
    acc = vi && (ready_o === 1'b1);
    drn = (valid_o === 1'b1) && ri;
    if (valid_o === 1'b1 && ri) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL spurious_out: got S=%0d D=%0d expected no result", S_o, D_o);
      end else begin
        e = sb.pop_front();
        if (S_o !== e.s || D_o !== e.d) begin
          n_mis++;
          $display("FAIL result: got S=%0d D=%0d expected S=%0d D=%0d", S_o, D_o, e.s, e.d);
        end
      end
      out_count++;
    end
    if (acc) begin
      sb.push_back(ref_model(a, b));
      acc_count++;
`ifdef NTT_MODADD_RANGE_CHECK_EN
      if (a >= Q || b >= Q) err_exp = 1'b1;
`endif
    end
    occ = occ + (acc ? 1 : 0) - (drn ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete(); occ = 0; err_exp = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || occ != 0) && budget < 10) begin
      step(1'b0, 0, 0, 1'b1);
      budget++;
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
      sb.delete(); occ = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || S_o !== '0 || D_o !== '0 || err_o !== 1'b0 || ready_o !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_state: got v=%b S=%0d D=%0d err=%b rdy=%b expected 0 0 0 0 1",
               valid_o, S_o, D_o, err_o, ready_o);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 3328, 1, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    n_vec++;
    if (valid_o !== 1'b0) begin
      n_mis++;
      $display("FAIL latency_t1: got valid_o=%b expected 0", valid_o);
    end
    step(1'b0, 0, 0, 1'b1);
    n_vec++;
    if (valid_o !== 1'b1 || S_o !== 12'd0 || D_o !== 12'd3327) begin
      n_mis++;
      $display("FAIL latency_t2: got v=%b S=%0d D=%0d expected v=1 S=0 D=3327", valid_o, S_o, D_o);
    end
    drain();
  endtask

  task automatic test_wrap();
    step(1'b1, 0, 1, 1'b1);
    step(1'b1, 3328, 3328, 1'b1);
    step(1'b1, 1664, 1665, 1'b1);
    step(1'b1, 5, 5, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    int base;
    base = out_count;
    for (int k = 0; k < 10; k++) begin
      step(k < 8, $urandom_range(Q-1), $urandom_range(Q-1), 1'b1);
      n_vec++;
      if (valid_o !== (k >= 2)) begin
        n_mis++;
        $display("FAIL b2b_valid cycle %0d: got %b expected %b", k, valid_o, k >= 2);
      end
    end
    n_vec++;
    if (out_count - base != 8) begin
      n_mis++;
      $display("FAIL b2b_count: got %0d expected 8", out_count - base);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    logic [WIDTH-1:0] hs, hd;
    a0 = acc_count;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, $urandom_range(Q-1), $urandom_range(Q-1), 1'b0);
      if (k == 2) begin hs = S_o; hd = D_o; end
      if (k > 2) begin
        n_vec++;
        if (S_o !== hs || D_o !== hd || valid_o !== 1'b1) begin
          n_mis++;
          $display("FAIL bp_stable: got v=%b S=%0d D=%0d expected v=1 S=%0d D=%0d",
                   valid_o, S_o, D_o, hs, hd);
        end
      end
    end
    n_vec++;
    if (acc_count - a0 != 2 || ready_o !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_accepted: got %0d accepts ready_o=%b expected 2 accepts ready_o=0",
               acc_count - a0, ready_o);
    end
    // Release while offering new pairs: full-but-draining must shift and accept together.
    step(1'b1, 100, 200, 1'b1);
    step(1'b1, 300, 7, 1'b1);
    drain();
  endtask

  task automatic test_reset_inflight();
    step(1'b1, 11, 22, 1'b0);
    step(1'b1, 33, 44, 1'b0);
    do_reset();
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || S_o !== '0 || D_o !== '0) begin
      n_mis++;
      $display("FAIL reset_flush: got v=%b S=%0d D=%0d expected 0 0 0", valid_o, S_o, D_o);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(3) != 0, $urandom_range(Q-1), $urandom_range(Q-1),
           $urandom_range(3) != 0);
    end
    drain();
  endtask

  task automatic test_range();
    do_reset();
    step(1'b1, 4000, 5, 1'b1);
    step(1'b1, 10, 20, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    n_vec++;
    if (S_o !== 12'd676 || D_o !== 12'd3995) begin
      n_mis++;
      $display("FAIL range_result: got S=%0d D=%0d expected S=676 D=3995", S_o, D_o);
    end
    for (int k = 0; k < 5; k++) step(1'b1, $urandom_range(Q-1), $urandom_range(Q-1), 1'b1);
    drain();
    do_reset();
    #1;
    n_vec++;
    if (err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL range_clear: got err_o=%b expected 0", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    test_random();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
